// File: rtl/regfile_dump.sv
// Debug readout engine: walks the register-file read port from register 0 to NREGS-1
// and streams each register as an (index, data) beat while holding off writeback.
module regfile_dump #(
  parameter int NREGS = 32,
  parameter int AW    = 5,
  parameter int DW    = 32
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  output logic          busy,
  output logic          rf_hold,
  output logic          done,
  output logic [AW-1:0] rf_ra,
  input  logic [DW-1:0] rf_rd,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [AW-1:0] out_idx,
  output logic [DW-1:0] out_data,
  output logic          out_last
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_READ   = 2'd1,
    S_SEND   = 2'd2,
    S_FINISH = 2'd3
  } state_t;

  localparam logic [AW-1:0] LAST_IDX = AW'(NREGS - 1);

  state_t        r_state;
  logic [AW-1:0] r_idx;
  logic          r_busy;
  logic          r_done;
  logic          r_valid;
  logic          r_last;
  logic [AW-1:0] r_out_idx;
  logic [DW-1:0] r_out_data;
  logic          w_addr_en;
  logic          w_hshake;

  // The read port only follows the counter while a register is being fetched or held.
  assign w_addr_en = (r_state == S_READ) || (r_state == S_SEND);
  assign w_hshake  = r_valid && out_ready;

  assign rf_ra     = w_addr_en ? r_idx : '0;
  assign busy      = r_busy;
  assign rf_hold   = r_busy;
  assign done      = r_done;
  assign out_valid = r_valid;
  assign out_idx   = r_out_idx;
  assign out_data  = r_out_data;
  assign out_last  = r_last;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= S_IDLE;
      r_idx      <= '0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
      r_valid    <= 1'b0;
      r_last     <= 1'b0;
      r_out_idx  <= '0;
      r_out_data <= '0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_idx   <= '0;
            r_busy  <= 1'b1;
            r_state <= S_READ;
          end
        end
        S_READ: begin
          r_out_data <= rf_rd;
          r_out_idx  <= r_idx;
          r_last     <= (r_idx == LAST_IDX);
          r_valid    <= 1'b1;
          r_state    <= S_SEND;
        end
        S_SEND: begin
          // Beat contents stay frozen until the consumer takes them.
          if (w_hshake) begin
            r_valid <= 1'b0;
            if (r_last) begin
              r_done  <= 1'b1;
              r_state <= S_FINISH;
            end else begin
              r_idx   <= r_idx + AW'(1);
              r_state <= S_READ;
            end
          end
        end
        S_FINISH: begin
          r_busy  <= 1'b0;
          r_state <= S_IDLE;
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_regfile_dump.sv
// Bench for regfile_dump: a register-file array model plus a per-beat cycle schedule
// derived from the handshake timing rules, compared every cycle against the DUT.
module tb_regfile_dump;
  localparam int N  = 32;
  localparam int AW = 5;
  localparam int DW = 32;

  logic          clk = 1'b0;
  logic          rst;
  logic          start;
  logic          busy;
  logic          rf_hold;
  logic          done;
  logic [AW-1:0] rf_ra;
  logic [DW-1:0] rf_rd;
  logic          out_valid;
  logic          out_ready;
  logic [AW-1:0] out_idx;
  logic [DW-1:0] out_data;
  logic          out_last;
  logic          corrupt;

  logic [DW-1:0] mem [N];
  int vstart [N];
  int vend   [N];
  int done_cyc;
  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  assign rf_rd = corrupt ? (mem[rf_ra] ^ 32'hA5A5_F00F) : mem[rf_ra];

  regfile_dump #(.NREGS(N), .AW(AW), .DW(DW)) dut (
    .clk(clk), .rst(rst), .start(start), .busy(busy), .rf_hold(rf_hold),
    .done(done), .rf_ra(rf_ra), .rf_rd(rf_rd), .out_valid(out_valid),
    .out_ready(out_ready), .out_idx(out_idx), .out_data(out_data),
    .out_last(out_last)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_reset_vals(input string tag);
    chk({tag, "_busy"},      32'(busy),      32'd0);
    chk({tag, "_rf_hold"},   32'(rf_hold),   32'd0);
    chk({tag, "_done"},      32'(done),      32'd0);
    chk({tag, "_rf_ra"},     32'(rf_ra),     32'd0);
    chk({tag, "_out_valid"}, 32'(out_valid), 32'd0);
    chk({tag, "_out_idx"},   32'(out_idx),   32'd0);
    chk({tag, "_out_data"},  32'(out_data),  32'd0);
    chk({tag, "_out_last"},  32'(out_last),  32'd0);
  endtask

  // Beat k: one READ cycle, then valid for 1 + stall cycles; done follows the last beat.
  task automatic build_sched(input int sb, input int sc);
    int t;
    t = 1;
    for (int k = 0; k < N; k++) begin
      vstart[k] = t + 1;
      vend[k]   = t + 1 + ((k == sb) ? sc : 0);
      t         = vend[k] + 1;
    end
    done_cyc = t;
  endtask

  task automatic run_dump(input string tag, input int sb, input int sc, input int cb,
                          input bit pulses, input int ab);
    int beats;
    int k;
    int r;
    beats = 0;
    build_sched(sb, sc);
    start = 1'b1;
    out_ready = 1'b1;
    corrupt = 1'b0;
    chk({tag, "_c0_busy"}, 32'(busy), 32'd0);
    for (int c = 1; c <= done_cyc + 1; c++) begin
      step();
      start = pulses && (c == 10 || c == 40 || c == done_cyc);
      out_ready = !(sb >= 0 && c >= vstart[sb] && c < vstart[sb] + sc);
      k = -1;
      r = -1;
      for (int j = 0; j < N; j++) begin
        if (c >= vstart[j] && c <= vend[j]) k = j;
        if (c == vstart[j] - 1) r = j;
      end
      corrupt = (k >= 0) && (k == cb);
      if (ab >= 0 && c == vstart[ab]) begin
        rst = 1'b1;
        start = 1'b0;
        step();
        rst = 1'b0;
        check_reset_vals({tag, "_abort"});
        step();
        chk({tag, "_abort_idle_busy"}, 32'(busy), 32'd0);
        chk({tag, "_abort_idle_done"}, 32'(done), 32'd0);
        return;
      end
      chk($sformatf("%s_valid_c%0d", tag, c), 32'(out_valid), 32'(k >= 0));
      chk($sformatf("%s_busy_c%0d", tag, c), 32'(busy), 32'(c <= done_cyc));
      chk($sformatf("%s_hold_c%0d", tag, c), 32'(rf_hold), 32'(c <= done_cyc));
      chk($sformatf("%s_done_c%0d", tag, c), 32'(done), 32'(c == done_cyc));
      if (k >= 0) begin
        chk($sformatf("%s_idx_c%0d", tag, c), 32'(out_idx), 32'(k));
        chk($sformatf("%s_data_c%0d", tag, c), out_data, mem[k]);
        chk($sformatf("%s_last_c%0d", tag, c), 32'(out_last), 32'(k == N - 1));
        chk($sformatf("%s_ra_send_c%0d", tag, c), 32'(rf_ra), 32'(k));
      end else if (r >= 0) begin
        chk($sformatf("%s_ra_read_c%0d", tag, c), 32'(rf_ra), 32'(r));
      end
      if (out_valid && out_ready) beats++;
    end
    start = 1'b0;
    corrupt = 1'b0;
    chk({tag, "_beats"}, 32'(beats), 32'(N));
    for (int i = 0; i < 4; i++) begin
      step();
      chk($sformatf("%s_idle_busy_%0d", tag, i), 32'(busy), 32'd0);
      chk($sformatf("%s_idle_done_%0d", tag, i), 32'(done), 32'd0);
      chk($sformatf("%s_idle_valid_%0d", tag, i), 32'(out_valid), 32'd0);
    end
  endtask

  task automatic fill_random();
    for (int i = 0; i < N; i++) mem[i] = $urandom;
  endtask

  initial begin
    rst = 1'b1;
    start = 1'b0;
    out_ready = 1'b1;
    corrupt = 1'b0;
    for (int i = 0; i < N; i++) mem[i] = '0;
    step();
    step();
    rst = 1'b0;
    step();
    step();

    // Reset mid-idle with start asserted alongside it.
    rst = 1'b1;
    start = 1'b1;
    step();
    step();
    check_reset_vals("rst");
    rst = 1'b0;
    start = 1'b0;
    step();
    check_reset_vals("post_rst");
    step();

    for (int i = 0; i < N; i++) mem[i] = 32'(i) * 32'h0101_0101;
    run_dump("full", -1, 0, -1, 1'b0, -1);

    fill_random();
    run_dump("bp", 5, 3, 3, 1'b0, -1);

    fill_random();
    run_dump("busy_start", -1, 0, -1, 1'b1, -1);

    fill_random();
    run_dump("abort", -1, 0, -1, 1'b0, 10);
    fill_random();
    run_dump("fresh", -1, 0, -1, 1'b0, -1);

    fill_random();
    run_dump("rand_bp", int'($urandom_range(0, N - 1)), int'($urandom_range(1, 5)),
             int'($urandom_range(0, N - 1)), 1'b0, -1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
